// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] OPC_ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC register, one-entry output register, redirect/fault handling.
// Optional IFETCH_ECALL_HALT_EN: an accepted ECALL parks the fetcher in HALT until a redirect.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic        fetch_fault
);

    // The ROM is indexed by addr[9:2], so it cannot hold more than 256 words.
    generate
        if (ROM_WORDS < 1 || ROM_WORDS > 256) begin : g_bad_rom_words
            $error("ifetch_ctrl: ROM_WORDS must be in 1..256");
        end
    endgenerate

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         valid_next;
    logic [31:0]  instr_next;
    logic [31:0]  out_pc_next;
    logic         accept;
    logic         redirect_bad;

    assign rom_addr     = pc;
    assign accept       = if_valid && if_ready;
    assign redirect_bad = redirect_pc[1:0] != 2'b00;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next  = state;
        pc_next     = pc;
        valid_next  = if_valid;
        instr_next  = if_instr;
        out_pc_next = if_pc;

        unique case (state)
            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    // A coincident handshake is simply allowed to complete; the flush follows.
                    valid_next = 1'b0;
                    if (redirect_bad) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_RUN;
                        pc_next    = redirect_pc;
                    end
                end else if (state == ST_RUN && (!if_valid || if_ready)) begin
`ifdef IFETCH_ECALL_HALT_EN
                    if (accept && if_instr == OPC_ECALL) begin
                        state_next = ST_HALT;
                        valid_next = 1'b0;
                    end else begin
                        valid_next  = 1'b1;
                        instr_next  = rom_instr;
                        out_pc_next = pc;
                        pc_next     = pc + 32'd4;
                    end
`else
                    valid_next  = 1'b1;
                    instr_next  = rom_instr;
                    out_pc_next = pc;
                    pc_next     = pc + 32'd4;
`endif
                end
            end
            ST_FAULT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = ST_FAULT;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            if_valid <= valid_next;
            if_instr <= instr_next;
            if_pc    <= out_pc_next;
        end
    end

    assign fetch_fault = state == ST_FAULT;
`ifdef IFETCH_ECALL_HALT_EN
    assign halted = state == ST_HALT;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL provide parameter ROM_WORDS, default 256, the instruction ROM depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rom_addr  output  32  byte address to instruction ROM (combinational ROM, word index = addr[9:2]).
REQ-006 SHALL have port rom_instr  input  32  ROM read data, valid in the same cycle as rom_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-010 SHALL have port if_ready  input  1  decode accepts the instruction this cycle.
REQ-011 SHALL have port if_instr  output  32  fetched instruction word.
REQ-012 SHALL have port if_pc  output  32  byte address of if_instr.
REQ-013 SHALL have port halted  output  1  high while in HALT state.
REQ-014 SHALL have port fetch_fault  output  1  high while in FAULT state.

Function
REQ-015 SHALL hold a PC register and a single output register (if_valid, if_instr, if_pc); rom_addr = PC at all times.
REQ-016 SHALL implement states RUN, HALT, FAULT.
REQ-017 In RUN, when output is empty or (if_valid && if_ready), SHALL load rom_instr/PC into output register, set if_valid, and PC <= PC + 4.
REQ-018 In RUN, when if_valid && !if_ready, SHALL hold output register and PC unchanged (stall).
REQ-019 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 -> 0); rom_addr upper bits are passed through unmodified.
REQ-020 First if_valid SHALL occur in the first cycle after rst deasserts (latency 1 from fetch to output).
REQ-021 redirect_valid SHALL have priority over all fetch activity: clear if_valid, PC <= redirect_pc; fetch from target begins next cycle (redirect-to-valid latency 2).
REQ-022 Redirect coinciding with if_valid && if_ready SHALL count the handshake as completed and still flush per REQ-021.
REQ-023 redirect_pc[1:0] != 0 SHALL enter FAULT: if_valid cleared, fetch_fault high, no fetching, redirects ignored until rst.
REQ-024 redirect_valid in HALT with aligned target SHALL return to RUN per REQ-021.

Reset
REQ-025 On rst SHALL set PC=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_fault=0.
REQ-026 rst asserted mid-stall or mid-redirect SHALL discard all pending state; rst wins over redirect_valid.

Configuration
REQ-027 Macro IFETCH_ECALL_HALT_EN defined: when the output instruction equals ECALL (32'h0000_0073) and is accepted (if_valid && if_ready), SHALL enter HALT next cycle, stop fetching, hold if_valid=0, halted=1.
REQ-028 Macro IFETCH_ECALL_HALT_EN undefined: ECALL SHALL be fetched and handed off as any other instruction; halted SHALL be tied 0.

Structure
REQ-029 SHALL place state enum, OPC_ECALL (32'h0000_0073) and NOP (32'h0000_0013) constants in shared package ifetch_pkg.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 ROM {NOP, ADDI x1,x0,1, ADDI x2,x0,2, ADD x3,x1,x2, ECALL}, if_ready=1 -> if_pc 0,4,8,C,10 on consecutive cycles with matching words 00000013,00100093,00200113,002081B3,00000073.
REQ-032 Same program, if_ready low 3 cycles while if_pc=4 -> if_instr held 00100093, rom_addr held 8, then resumes at 8.
REQ-033 redirect_valid with redirect_pc=0x0C while if_pc=4 -> if_valid 0 next cycle, then if_pc=0x0C/002081B3.
REQ-034 redirect_pc=0x06 -> fetch_fault=1, if_valid=0 until rst; rst -> if_pc sequence restarts at RESET_PC.
REQ-035 With IFETCH_ECALL_HALT_EN, ECALL at 0x10 accepted -> halted=1, if_valid=0; redirect to 0x4 -> RUN, if_pc=4 two cycles later. Without macro: fetch continues at 0x14.
REQ-036 PC=0xFFFF_FFFC via redirect, if_ready=1 -> next if_pc=0x0000_0000.
